// File: rtl/spi_slave_sequencer.sv
// Hardware sequencer for an 8-bit SPI slave register port: drains rx bytes, feeds tx bytes,
// and periodically polls status to clear and count overrun errors.
module spi_slave_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int POLL_INTERVAL = 64,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     spi_select,
  output logic [2:0]               mem_addr,
  output logic                     read_n,
  output logic                     write_n,
  output logic [15:0]              data_from_cpu,
  input  logic [15:0]              data_to_cpu,
  input  logic                     dataavailable,
  input  logic                     readyfordata,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [ERR_CNT_WIDTH-1:0] roe_count,
  output logic [ERR_CNT_WIDTH-1:0] toe_count,
  output logic                     busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(POLL_INTERVAL);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] POLL_ONE  = TW'(1);
  localparam logic [TW-1:0] POLL_ZERO = TW'(0);

  typedef enum logic [3:0] {
    IDLE, RD_DATA1, RD_DATA2, WR_DATA1, WR_DATA2,
    RD_STAT1, RD_STAT2, CLR_STAT1, CLR_STAT2
  } state_t;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  state_t state_r, state_nxt_s;
  logic [7:0]    rx_mem_r [FIFO_DEPTH];
  logic [7:0]    tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r, rx_rd_ptr_nxt_s, tx_wr_ptr_r, tx_rd_ptr_r;
  logic [AW:0]   rx_cnt_r, rx_cnt_nxt_s, tx_cnt_r, tx_cnt_nxt_s;
  logic [7:0]    rx_head_r, rx_head_nxt_s, tx_head_s;
  logic          rx_valid_r, tx_ready_r, busy_r, last_rx_r, clr_pending_r;
  logic [TW-1:0] poll_cnt_r;
  logic [ERR_CNT_WIDTH-1:0] roe_cnt_r, toe_cnt_r;
  logic          sel_r, rd_n_r, wr_n_r, sel_nxt_s, rd_n_nxt_s, wr_n_nxt_s;
  logic [2:0]    addr_r, addr_nxt_s;
  logic [15:0]   dout_r, dout_nxt_s;
  logic          rx_full_s, tx_empty_s, rx_req_s, tx_req_s, poll_due_s;
  logic          rx_push_ok_s, rx_pop_s, tx_push_ok_s, tx_pop_s;
  logic          stat_roe_s, stat_toe_s, unused_s;

  assign rx_full_s    = (rx_cnt_r == CNT_FULL);
  assign tx_empty_s   = (tx_cnt_r == CNT_ZERO);
  assign rx_req_s     = dataavailable & ~rx_full_s;
  assign tx_req_s     = readyfordata & ~tx_empty_s;
  assign poll_due_s   = (poll_cnt_r == POLL_LAST);
  assign stat_roe_s   = data_to_cpu[3];
  assign stat_toe_s   = data_to_cpu[4];
  assign unused_s     = ^data_to_cpu[15:8];
  assign tx_head_s    = tx_mem_r[tx_rd_ptr_r];
  assign rx_pop_s     = rx_ready & (rx_cnt_r != CNT_ZERO);
  assign rx_push_ok_s = (state_r == RD_DATA2) & (~rx_full_s | rx_pop_s);
  assign tx_pop_s     = (state_r == WR_DATA2) & ~tx_empty_s;
  assign tx_push_ok_s = tx_valid & tx_ready_r;
  assign rx_rd_ptr_nxt_s = rx_pop_s ? rx_rd_ptr_r + PTR_ONE : rx_rd_ptr_r;
  // The new byte becomes the head when it lands in the slot the read pointer is about to show.
  assign rx_head_nxt_s = (rx_push_ok_s && (rx_wr_ptr_r == rx_rd_ptr_nxt_s)) ?
                         data_to_cpu[7:0] : rx_mem_r[rx_rd_ptr_nxt_s];

  // Next-state: a pending clear always runs; otherwise alternate rx/tx, then poll.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_pending_r) begin
          state_nxt_s = CLR_STAT1;
        end else if (enable) begin
          if (rx_req_s && tx_req_s) begin
            state_nxt_s = last_rx_r ? WR_DATA1 : RD_DATA1;
          end else if (rx_req_s) begin
            state_nxt_s = RD_DATA1;
          end else if (tx_req_s) begin
            state_nxt_s = WR_DATA1;
          end else if (poll_due_s) begin
            state_nxt_s = RD_STAT1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_DATA1:  state_nxt_s = RD_DATA2;
      WR_DATA1:  state_nxt_s = WR_DATA2;
      RD_STAT1:  state_nxt_s = RD_STAT2;
      CLR_STAT1: state_nxt_s = CLR_STAT2;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // Bus decode from the next state so the bus pins come straight from flops.
  always_comb begin
    sel_nxt_s  = 1'b0;
    addr_nxt_s = 3'd0;
    rd_n_nxt_s = 1'b1;
    wr_n_nxt_s = 1'b1;
    dout_nxt_s = 16'h0000;
    case (state_nxt_s)
      RD_DATA1, RD_DATA2: begin
        sel_nxt_s  = 1'b1;
        rd_n_nxt_s = 1'b0;
      end
      WR_DATA1, WR_DATA2: begin
        sel_nxt_s  = 1'b1;
        wr_n_nxt_s = 1'b0;
        addr_nxt_s = 3'd1;
        dout_nxt_s = {8'h00, tx_head_s};
      end
      RD_STAT1, RD_STAT2: begin
        sel_nxt_s  = 1'b1;
        rd_n_nxt_s = 1'b0;
        addr_nxt_s = 3'd2;
      end
      CLR_STAT1, CLR_STAT2: begin
        sel_nxt_s  = 1'b1;
        wr_n_nxt_s = 1'b0;
        addr_nxt_s = 3'd2;
      end
      default: sel_nxt_s = 1'b0;
    endcase
  end

  // FIFO occupancy update; pushes and pops are independent.
  always_comb begin
    rx_cnt_nxt_s = rx_cnt_r;
    tx_cnt_nxt_s = tx_cnt_r;
    case ({rx_push_ok_s, rx_pop_s})
      2'b10:   rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
      2'b01:   rx_cnt_nxt_s = rx_cnt_r - CNT_ONE;
      default: rx_cnt_nxt_s = rx_cnt_r;
    endcase
    case ({tx_push_ok_s, tx_pop_s})
      2'b10:   tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
      2'b01:   tx_cnt_nxt_s = tx_cnt_r - CNT_ONE;
      default: tx_cnt_nxt_s = tx_cnt_r;
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      addr_r  <= 3'd0;
      rd_n_r  <= 1'b1;
      wr_n_r  <= 1'b1;
      dout_r  <= 16'h0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      addr_r  <= addr_nxt_s;
      rd_n_r  <= rd_n_nxt_s;
      wr_n_r  <= wr_n_nxt_s;
      dout_r  <= dout_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (rx_push_ok_s) rx_mem_r[rx_wr_ptr_r] <= data_to_cpu[7:0];
    if (tx_push_ok_s) tx_mem_r[tx_wr_ptr_r] <= tx_data;
  end

  // FIFO pointers, occupancy and registered stream flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_r <= {AW{1'b0}};
      rx_rd_ptr_r <= {AW{1'b0}};
      rx_cnt_r    <= CNT_ZERO;
      rx_valid_r  <= 1'b0;
      rx_head_r   <= 8'h00;
      tx_wr_ptr_r <= {AW{1'b0}};
      tx_rd_ptr_r <= {AW{1'b0}};
      tx_cnt_r    <= CNT_ZERO;
      tx_ready_r  <= 1'b1;
    end else begin
      if (rx_push_ok_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      if (tx_push_ok_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      if (tx_pop_s)     tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      rx_rd_ptr_r <= rx_rd_ptr_nxt_s;
      rx_cnt_r    <= rx_cnt_nxt_s;
      rx_valid_r  <= (rx_cnt_nxt_s != CNT_ZERO);
      rx_head_r   <= rx_head_nxt_s;
      tx_cnt_r    <= tx_cnt_nxt_s;
      tx_ready_r  <= (tx_cnt_nxt_s != CNT_FULL);
    end
  end

  // Poll timer, arbitration history, pending clear and error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt_r    <= POLL_ZERO;
      last_rx_r     <= 1'b0;
      clr_pending_r <= 1'b0;
      roe_cnt_r     <= {ERR_CNT_WIDTH{1'b0}};
      toe_cnt_r     <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      if (!enable) begin
        poll_cnt_r <= POLL_ZERO;
      end else if (state_r == IDLE) begin
        if (state_nxt_s == RD_STAT1) poll_cnt_r <= POLL_ZERO;
        else if (!poll_due_s)        poll_cnt_r <= poll_cnt_r + POLL_ONE;
      end
      if (state_r == RD_DATA2) last_rx_r <= 1'b1;
      if (state_r == WR_DATA2) last_rx_r <= 1'b0;
      if (state_r == CLR_STAT1) clr_pending_r <= 1'b0;
      if (state_r == RD_STAT2) begin
        clr_pending_r <= stat_roe_s | stat_toe_s;
        if (stat_roe_s) roe_cnt_r <= sat_inc(roe_cnt_r);
        if (stat_toe_s) toe_cnt_r <= sat_inc(toe_cnt_r);
      end
    end
  end

  assign spi_select    = sel_r;
  assign mem_addr      = addr_r;
  assign read_n        = rd_n_r;
  assign write_n       = wr_n_r;
  assign data_from_cpu = dout_r;
  assign rx_data       = rx_head_r;
  assign rx_valid      = rx_valid_r;
  assign tx_ready      = tx_ready_r;
  assign roe_count     = roe_cnt_r;
  assign toe_count     = toe_cnt_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Scoreboard bench: stimulus queues expected bus accesses and rx bytes; a monitor compares them.
module tb_spi_slave_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0;
  logic        spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        dataavailable = 1'b0, readyfordata = 1'b0;
  logic [7:0]  rx_data, tx_data = 8'h00;
  logic        rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready, busy;
  logic [7:0]  roe_count, toe_count;
  logic [7:0]  slave_rx_byte = 8'h00;
  logic [15:0] slave_status = 16'h0000;

  int n_checks = 0;
  int n_fail = 0;
  logic [19:0] exp_bus_q[$];   // {is_write, addr, data_from_cpu}
  logic [7:0]  exp_rx_q[$];
  logic        in_acc = 1'b0;

  always #5 clk = ~clk;

  assign data_to_cpu = (mem_addr == 3'd2) ? slave_status : {8'h00, slave_rx_byte};

  spi_slave_sequencer #(.FIFO_DEPTH(4), .POLL_INTERVAL(64), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .dataavailable(dataavailable), .readyfordata(readyfordata), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .roe_count(roe_count), .toe_count(toe_count), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: reassemble bus accesses and rx transfers, compare against the queues.
  initial begin
    int acc_len;
    logic [19:0] acc_word, cur;
    acc_len = 0;
    acc_word = 20'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_acc = 1'b0;
      end else begin
        if (spi_select) begin
          cur = {~write_n, mem_addr, data_from_cpu};
          check("strobe_onehot", {30'd0, read_n, write_n} == 32'd1 || {30'd0, read_n, write_n} == 32'd2, 32'd1);
          if (!in_acc) begin
            in_acc = 1'b1;
            acc_len = 1;
            acc_word = cur;
          end else begin
            acc_len++;
            check("acc_stable", {12'd0, cur}, {12'd0, acc_word});
          end
        end else if (in_acc) begin
          check("bus_idle_strobes", {30'd0, read_n, write_n}, 32'd3);
          check("acc_len", acc_len, 32'd2);
          if (exp_bus_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_access: got %0h, expected no access", acc_word);
          end else begin
            check("bus_access", {12'd0, acc_word}, {12'd0, exp_bus_q.pop_front()});
          end
          in_acc = 1'b0;
        end
        if (rx_valid && rx_ready) begin
          if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rx: got %0h, expected no byte", rx_data);
          end else begin
            check("rx_data_stream", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; dataavailable = 1'b0; readyfordata = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0;
    tick();
    tick();
    check("bus_q_drained", exp_bus_q.size(), 32'd0);
    exp_bus_q.delete();
    exp_rx_q.delete();
    reset = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_acc_start(input string name);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!spi_select) break;
    end
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (spi_select) break;
    end
    check(name, {31'd0, spi_select}, 32'd1);
  endtask

  task automatic wait_bus_drain(input string name, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (exp_bus_q.size() == 0 && !in_acc && !busy) break;
    end
    check(name, exp_bus_q.size(), 32'd0);
  endtask

  task automatic drain_rx();
    tick();
    rx_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!rx_valid) break;
    end
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("rx_q_consumed", exp_rx_q.size(), 32'd0);
    check("rx_valid_after_drain", {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_select", {31'd0, spi_select}, 32'd0);
    check("rst_read_n", {31'd0, read_n}, 32'd1);
    check("rst_write_n", {31'd0, write_n}, 32'd1);
    check("rst_addr", {29'd0, mem_addr}, 32'd0);
    check("rst_dout", {16'd0, data_from_cpu}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_roe", {24'd0, roe_count}, 32'd0);
    check("rst_toe", {24'd0, toe_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single rx byte
    slave_rx_byte = 8'hA5;
    exp_bus_q.push_back({1'b0, 3'd0, 16'h0000});
    exp_rx_q.push_back(8'hA5);
    tick();
    enable = 1'b1;
    dataavailable = 1'b1;
    wait_acc_start("t1_read_start");
    dataavailable = 1'b0;
    wait_bus_drain("t1_drain", 100);
    check("t1_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("t1_rx_data", {24'd0, rx_data}, 32'h0000_00A5);
    drain_rx();

    // Two tx bytes
    do_reset();
    exp_bus_q.push_back({1'b1, 3'd1, 16'h0011});
    exp_bus_q.push_back({1'b1, 3'd1, 16'h0022});
    tick();
    enable = 1'b1;
    readyfordata = 1'b1;
    push_tx(8'h11);
    push_tx(8'h22);
    wait_bus_drain("t2_drain", 100);
    repeat (10) @(negedge clk);
    check("t2_no_extra_write", exp_bus_q.size(), 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_tx_ready", {31'd0, tx_ready}, 32'd1);

    // Alternation, then rx FIFO full stops reads
    do_reset();
    slave_rx_byte = 8'h5A;
    tick();
    push_tx(8'h33);
    push_tx(8'h44);
    push_tx(8'h55);
    exp_bus_q.push_back({1'b0, 3'd0, 16'h0000});
    exp_bus_q.push_back({1'b1, 3'd1, 16'h0033});
    exp_bus_q.push_back({1'b0, 3'd0, 16'h0000});
    exp_bus_q.push_back({1'b1, 3'd1, 16'h0044});
    exp_bus_q.push_back({1'b0, 3'd0, 16'h0000});
    exp_bus_q.push_back({1'b1, 3'd1, 16'h0055});
    exp_bus_q.push_back({1'b0, 3'd0, 16'h0000});
    repeat (4) exp_rx_q.push_back(8'h5A);
    enable = 1'b1;
    dataavailable = 1'b1;
    readyfordata = 1'b1;
    wait_bus_drain("t3_drain", 200);
    repeat (30) @(negedge clk);
    check("t3_full_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("t3_full_rx_data", {24'd0, rx_data}, 32'h0000_005A);
    check("t3_full_idle", {31'd0, busy}, 32'd0);
    tick();
    enable = 1'b0;
    dataavailable = 1'b0;
    readyfordata = 1'b0;
    drain_rx();

    // Status poll with both overrun bits
    do_reset();
    slave_status = 16'h0018;
    exp_bus_q.push_back({1'b0, 3'd2, 16'h0000});
    exp_bus_q.push_back({1'b1, 3'd2, 16'h0000});
    tick();
    enable = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (spi_select) break;
      n++;
    end
    check("t4_poll_delay", n, 32'd64);
    wait_bus_drain("t4_drain", 100);
    tick();
    enable = 1'b0;
    slave_status = 16'h0000;
    check("t4_roe", {24'd0, roe_count}, 32'd1);
    check("t4_toe", {24'd0, toe_count}, 32'd1);

    // ROE counter saturation over 300 polls
    do_reset();
    slave_status = 16'h0008;
    for (int i = 0; i < 300; i++) begin
      exp_bus_q.push_back({1'b0, 3'd2, 16'h0000});
      exp_bus_q.push_back({1'b1, 3'd2, 16'h0000});
    end
    tick();
    enable = 1'b1;
    wait_bus_drain("t5_drain", 30000);
    tick();
    enable = 1'b0;
    slave_status = 16'h0000;
    check("t5_roe_sat", {24'd0, roe_count}, 32'd255);
    check("t5_toe", {24'd0, toe_count}, 32'd0);

    // Reset during RD_DATA2 of the second read
    slave_rx_byte = 8'h77;
    exp_bus_q.push_back({1'b0, 3'd0, 16'h0000});
    tick();
    enable = 1'b1;
    dataavailable = 1'b1;
    wait_acc_start("t7_first_read");
    wait_acc_start("t7_second_read");
    @(posedge clk);
    #1;
    reset = 1'b1;
    enable = 1'b0;
    dataavailable = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t7_select", {31'd0, spi_select}, 32'd0);
    check("t7_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t7_roe", {24'd0, roe_count}, 32'd0);
    check("t7_toe", {24'd0, toe_count}, 32'd0);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_bus_q", exp_bus_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
